// File: rtl/cache_hierarchy_types.sv
`default_nettype none
// ============================================================================
//  Module  : cache_hierarchy_types (package)
//  Purpose : Shared types for the cache hierarchy. Holds the legacy single
//            victim record (vc_t) plus the victim cache state enum, default
//            geometry and the per-entry record layout.
//  Ports   : none (package)
//  Rev     : 1.0  initial victim cache types
// ============================================================================
package cache_hierarchy_types;

  localparam int VC_NUM_ENTRIES = 8;
  localparam int VC_ADDR_W      = 32;
  localparam int VC_LINE_W      = 256;
  localparam int VC_OFFSET_W    = 5;
  localparam int VC_TAG_W       = VC_ADDR_W - VC_OFFSET_W;

  // Legacy single-entry victim record.
  typedef struct packed {
    logic                 valid;
    logic [VC_ADDR_W-1:0] addr;
    logic [VC_LINE_W-1:0] line;
  } vc_t;

  typedef enum logic [2:0] {
    VC_IDLE   = 3'd0,
    VC_LOOKUP = 3'd1,
    VC_INSERT = 3'd2,
    VC_WB     = 3'd3,
    VC_COMMIT = 3'd4
  } vc_state_t;

  // One victim cache entry at default widths.
  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [VC_TAG_W-1:0]  tag;
    logic [VC_LINE_W-1:0] data;
  } vc_entry_t;

endpackage : cache_hierarchy_types
`default_nettype wire

// File: rtl/victim_cache_match.sv
`default_nettype none
// ============================================================================
//  Module  : victim_cache_match
//  Purpose : Combinational tag compare across all victim entries.
//  Ports   : valid             - per-entry valid bits
//            tags              - per-entry tags
//            cmp_tag           - tag being searched
//            hit / hit_idx     - a valid entry holds cmp_tag, and its index
//            any_invalid       - at least one free entry
//            first_invalid_idx - lowest-index free entry
//  Rev     : 1.0  initial
// ============================================================================
module victim_cache_match
  import cache_hierarchy_types::*;
#(
  parameter  int NUM_ENTRIES = VC_NUM_ENTRIES,
  parameter  int TAG_W       = VC_TAG_W,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-1:0]            valid,
  input  logic [NUM_ENTRIES-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]                  cmp_tag,
  output logic                              hit,
  output logic [IDX_W-1:0]                  hit_idx,
  output logic [IDX_W-1:0]                  first_invalid_idx,
  output logic                              any_invalid
);

  logic [NUM_ENTRIES-1:0] match_vec;

  generate
    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_cmp
      assign match_vec[i] = valid[i] && (tags[i] == cmp_tag);
    end
  endgenerate

  // Scanning downward leaves the lowest matching / free index as the winner.
  // Inserts never create duplicates, so at most one match_vec bit is set.
  always_comb begin
    hit               = |match_vec;
    any_invalid       = ~&valid;
    hit_idx           = '0;
    first_invalid_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (match_vec[i]) hit_idx = IDX_W'(i);
      if (!valid[i])    first_invalid_idx = IDX_W'(i);
    end
  end

endmodule : victim_cache_match
`default_nettype wire

// File: rtl/victim_cache.sv
`default_nettype none
// ============================================================================
//  Module  : victim_cache
//  Purpose : Fully associative, exclusive victim cache between L1 and L2.
//            Lookup hits return the line and free the entry. Inserts reuse a
//            matching entry, else the lowest free entry, else the round-robin
//            entry; a dirty round-robin victim is written back first.
//  Ports   : clk, rst_n (synchronous, active low)
//            lookup_req/addr  -> lookup_resp/hit/data/dirty (1-cycle pulse)
//            insert_req/addr/data/dirty -> insert_ack (1-cycle pulse)
//            wb_write/address/wdata -> wb_resp (downstream writeback)
//            stat_hits/misses/writebacks (only with VICTIM_CACHE_STATS_EN)
//  Config  : define VICTIM_CACHE_STATS_EN to add saturating event counters.
//  Rev     : 1.0  initial
// ============================================================================
module victim_cache
  import cache_hierarchy_types::*;
#(
  parameter int NUM_ENTRIES = VC_NUM_ENTRIES,
  parameter int ADDR_W      = VC_ADDR_W,
  parameter int LINE_W      = VC_LINE_W,
  parameter int OFFSET_W    = VC_OFFSET_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_req,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_resp,
  output logic              lookup_hit,
  output logic [LINE_W-1:0] lookup_data,
  output logic              lookup_dirty,
  input  logic              insert_req,
  input  logic [ADDR_W-1:0] insert_addr,
  input  logic [LINE_W-1:0] insert_data,
  input  logic              insert_dirty,
  output logic              insert_ack,
  output logic              wb_write,
  output logic [ADDR_W-1:0] wb_address,
  output logic [LINE_W-1:0] wb_wdata,
  input  logic              wb_resp
`ifdef VICTIM_CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_writebacks
`endif
);

  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  // Entry storage
  logic [NUM_ENTRIES-1:0]            valid_q, valid_d, dirty_q, dirty_d;
  logic [NUM_ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [LINE_W-1:0]                 data_q [NUM_ENTRIES];
  logic [LINE_W-1:0]                 data_d [NUM_ENTRIES];

  // Control
  vc_state_t         state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  slot_q, slot_d;
  logic [TAG_W-1:0]  pend_tag_q, pend_tag_d;
  logic [LINE_W-1:0] pend_data_q, pend_data_d;
  logic              pend_dirty_q, pend_dirty_d;

  // Registered outputs
  logic              lookup_resp_q, lookup_resp_d;
  logic              lookup_hit_q, lookup_hit_d;
  logic [LINE_W-1:0] lookup_data_q, lookup_data_d;
  logic              lookup_dirty_q, lookup_dirty_d;
  logic              insert_ack_q, insert_ack_d;
  logic              wb_write_q, wb_write_d;
  logic [ADDR_W-1:0] wb_address_q, wb_address_d;
  logic [LINE_W-1:0] wb_wdata_q, wb_wdata_d;

  // Entry write port
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  wr_tag;
  logic [LINE_W-1:0] wr_data;
  logic              wr_dirty;

  // Match results
  logic [TAG_W-1:0]  cmp_tag;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx, first_invalid_idx;
  logic              any_invalid;

  // Offset bits never take part in matching.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{lookup_addr[OFFSET_W-1:0], insert_addr[OFFSET_W-1:0]};

  // Only one of the two request addresses is consulted per state, so a single
  // comparator bank serves both.
  assign cmp_tag = (state_q == VC_INSERT) ? insert_addr[ADDR_W-1:OFFSET_W]
                                          : lookup_addr[ADDR_W-1:OFFSET_W];

  victim_cache_match #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .TAG_W       (TAG_W)
  ) u_match (
    .valid             (valid_q),
    .tags              (tag_q),
    .cmp_tag           (cmp_tag),
    .hit               (hit),
    .hit_idx           (hit_idx),
    .first_invalid_idx (first_invalid_idx),
    .any_invalid       (any_invalid)
  );

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    tag_d          = tag_q;
    data_d         = data_q;
    rr_ptr_d       = rr_ptr_q;
    slot_d         = slot_q;
    pend_tag_d     = pend_tag_q;
    pend_data_d    = pend_data_q;
    pend_dirty_d   = pend_dirty_q;
    lookup_resp_d  = 1'b0;
    lookup_hit_d   = 1'b0;
    lookup_data_d  = '0;
    lookup_dirty_d = 1'b0;
    insert_ack_d   = 1'b0;
    wb_write_d     = wb_write_q;
    wb_address_d   = wb_address_q;
    wb_wdata_d     = wb_wdata_q;
    wr_en          = 1'b0;
    wr_idx         = '0;
    wr_tag         = cmp_tag;
    wr_data        = insert_data;
    wr_dirty       = insert_dirty;

    case (state_q)
      VC_IDLE: begin
        if (lookup_req)      state_d = VC_LOOKUP;
        else if (insert_req) state_d = VC_INSERT;
      end

      VC_LOOKUP: begin
        lookup_resp_d = 1'b1;
        if (hit) begin
          // Exclusive hierarchy: the line moves back to L1.
          lookup_hit_d     = 1'b1;
          lookup_data_d    = data_q[hit_idx];
          lookup_dirty_d   = dirty_q[hit_idx];
          valid_d[hit_idx] = 1'b0;
        end
        state_d = VC_IDLE;
      end

      VC_INSERT: begin
        if (hit) begin
          // Re-insert of a resident line: keep dirtiness sticky.
          wr_en        = 1'b1;
          wr_idx       = hit_idx;
          wr_dirty     = dirty_q[hit_idx] | insert_dirty;
          insert_ack_d = 1'b1;
          state_d      = VC_IDLE;
        end else if (any_invalid) begin
          wr_en        = 1'b1;
          wr_idx       = first_invalid_idx;
          insert_ack_d = 1'b1;
          state_d      = VC_IDLE;
        end else begin
          rr_ptr_d = rr_ptr_q + IDX_W'(1);
          if (dirty_q[rr_ptr_q]) begin
            // Park the new line until the dirty victim has left.
            wb_write_d   = 1'b1;
            wb_address_d = {tag_q[rr_ptr_q], {OFFSET_W{1'b0}}};
            wb_wdata_d   = data_q[rr_ptr_q];
            slot_d       = rr_ptr_q;
            pend_tag_d   = cmp_tag;
            pend_data_d  = insert_data;
            pend_dirty_d = insert_dirty;
            state_d      = VC_WB;
          end else begin
            // Clean victim is simply overwritten.
            wr_en        = 1'b1;
            wr_idx       = rr_ptr_q;
            insert_ack_d = 1'b1;
            state_d      = VC_IDLE;
          end
        end
      end

      VC_WB: begin
        if (wb_resp) begin
          wb_write_d = 1'b0;
          state_d    = VC_COMMIT;
        end
      end

      VC_COMMIT: begin
        wr_en        = 1'b1;
        wr_idx       = slot_q;
        wr_tag       = pend_tag_q;
        wr_data      = pend_data_q;
        wr_dirty     = pend_dirty_q;
        insert_ack_d = 1'b1;
        state_d      = VC_IDLE;
      end

      default: state_d = VC_IDLE;
    endcase

    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      dirty_d[wr_idx] = wr_dirty;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= VC_IDLE;
      valid_q        <= '0;
      dirty_q        <= '0;
      rr_ptr_q       <= '0;
      slot_q         <= '0;
      pend_dirty_q   <= 1'b0;
      lookup_resp_q  <= 1'b0;
      lookup_hit_q   <= 1'b0;
      lookup_data_q  <= '0;
      lookup_dirty_q <= 1'b0;
      insert_ack_q   <= 1'b0;
      wb_write_q     <= 1'b0;
      wb_address_q   <= '0;
      wb_wdata_q     <= '0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      dirty_q        <= dirty_d;
      rr_ptr_q       <= rr_ptr_d;
      slot_q         <= slot_d;
      pend_dirty_q   <= pend_dirty_d;
      lookup_resp_q  <= lookup_resp_d;
      lookup_hit_q   <= lookup_hit_d;
      lookup_data_q  <= lookup_data_d;
      lookup_dirty_q <= lookup_dirty_d;
      insert_ack_q   <= insert_ack_d;
      wb_write_q     <= wb_write_d;
      wb_address_q   <= wb_address_d;
      wb_wdata_q     <= wb_wdata_d;
    end
  end

  // Payload storage is qualified by valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_q       <= tag_d;
    data_q      <= data_d;
    pend_tag_q  <= pend_tag_d;
    pend_data_q <= pend_data_d;
  end

  assign lookup_resp  = lookup_resp_q;
  assign lookup_hit   = lookup_hit_q;
  assign lookup_data  = lookup_data_q;
  assign lookup_dirty = lookup_dirty_q;
  assign insert_ack   = insert_ack_q;
  assign wb_write     = wb_write_q;
  assign wb_address   = wb_address_q;
  assign wb_wdata     = wb_wdata_q;

`ifdef VICTIM_CACHE_STATS_EN
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_misses_q, stat_misses_d;
  logic [31:0] stat_wb_q, stat_wb_d;

  always_comb begin
    stat_hits_d   = stat_hits_q;
    stat_misses_d = stat_misses_q;
    stat_wb_d     = stat_wb_q;
    if (state_q == VC_LOOKUP && hit && !(&stat_hits_q))
      stat_hits_d = stat_hits_q + 32'd1;
    if (state_q == VC_LOOKUP && !hit && !(&stat_misses_q))
      stat_misses_d = stat_misses_q + 32'd1;
    if (state_q == VC_WB && wb_resp && !(&stat_wb_q))
      stat_wb_d = stat_wb_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
      stat_wb_q     <= '0;
    end else begin
      stat_hits_q   <= stat_hits_d;
      stat_misses_q <= stat_misses_d;
      stat_wb_q     <= stat_wb_d;
    end
  end

  assign stat_hits       = stat_hits_q;
  assign stat_misses     = stat_misses_q;
  assign stat_writebacks = stat_wb_q;
`endif

endmodule : victim_cache
`default_nettype wire

// File: tb/tb_victim_cache.sv
`default_nettype none
// ============================================================================
//  Module  : tb_victim_cache
//  Purpose : Self-checking bench for victim_cache (4 entries). Directed
//            scenarios followed by random lookups/inserts, compared against
//            an array-based model of the cache contents.
//  Rev     : 1.0  initial
// ============================================================================
`timescale 1ns/1ps
module tb_victim_cache;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int OW = 5;
  localparam int TW = AW - OW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lookup_req, lookup_resp, lookup_hit, lookup_dirty;
  logic [AW-1:0] lookup_addr;
  logic [LW-1:0] lookup_data;
  logic          insert_req, insert_dirty, insert_ack;
  logic [AW-1:0] insert_addr;
  logic [LW-1:0] insert_data;
  logic          wb_write, wb_resp;
  logic [AW-1:0] wb_address;
  logic [LW-1:0] wb_wdata;
`ifdef VICTIM_CACHE_STATS_EN
  logic [31:0]   stat_hits, stat_misses, stat_writebacks;
`endif

  always #5 clk = ~clk;

  victim_cache #(
    .NUM_ENTRIES (N),
    .ADDR_W      (AW),
    .LINE_W      (LW),
    .OFFSET_W    (OW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_req   (lookup_req),
    .lookup_addr  (lookup_addr),
    .lookup_resp  (lookup_resp),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data),
    .lookup_dirty (lookup_dirty),
    .insert_req   (insert_req),
    .insert_addr  (insert_addr),
    .insert_data  (insert_data),
    .insert_dirty (insert_dirty),
    .insert_ack   (insert_ack),
    .wb_write     (wb_write),
    .wb_address   (wb_address),
    .wb_wdata     (wb_wdata),
    .wb_resp      (wb_resp)
`ifdef VICTIM_CACHE_STATS_EN
    ,
    .stat_hits       (stat_hits),
    .stat_misses     (stat_misses),
    .stat_writebacks (stat_writebacks)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model: contents as a small array, replacement by the rules
  // "same line, else first free, else round robin".
  // ------------------------------------------------------------------------
  bit            m_v    [N];
  bit            m_d    [N];
  logic [TW-1:0] m_tag  [N];
  logic [LW-1:0] m_data [N];
  int            m_rr;
  int            m_hits, m_misses, m_wbs;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = 1'b0;
    end
    m_rr = 0; m_hits = 0; m_misses = 0; m_wbs = 0;
  endfunction

  function automatic void model_lookup(input logic [AW-1:0] a, output bit hit,
                                       output logic [LW-1:0] d, output bit dirty);
    hit = 1'b0; d = '0; dirty = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_v[i] && m_tag[i] == a[AW-1:OW]) begin
        hit = 1'b1; d = m_data[i]; dirty = m_d[i]; m_v[i] = 1'b0;
      end
    end
    if (hit) m_hits++; else m_misses++;
  endfunction

  function automatic void model_insert(input logic [AW-1:0] a, input logic [LW-1:0] d,
                                       input bit dirty, output bit wb,
                                       output logic [AW-1:0] wa, output logic [LW-1:0] wd);
    int slot = -1;
    wb = 1'b0; wa = '0; wd = '0;
    for (int i = 0; i < N; i++) begin
      if (m_v[i] && m_tag[i] == a[AW-1:OW]) slot = i;
    end
    if (slot >= 0) begin
      m_data[slot] = d;
      m_d[slot]    = m_d[slot] | dirty;
      return;
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (!m_v[i]) slot = i;
    end
    if (slot < 0) begin
      slot = m_rr;
      m_rr = (m_rr + 1) % N;
      if (m_d[slot]) begin
        wb = 1'b1;
        wa = {m_tag[slot], {OW{1'b0}}};
        wd = m_data[slot];
        m_wbs++;
      end
    end
    m_v[slot] = 1'b1; m_d[slot] = dirty; m_tag[slot] = a[AW-1:OW]; m_data[slot] = d;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ------------------------------------------------------------------------
  // Transaction tasks: entered #1 after a rising edge with the DUT idle.
  // ------------------------------------------------------------------------
  task automatic do_lookup(input logic [AW-1:0] a, input string tag);
    bit            eh, ed;
    logic [LW-1:0] edata;
    int            cyc = 0;
    model_lookup(a, eh, edata, ed);
    lookup_addr = a;
    lookup_req  = 1'b1;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!lookup_resp && cyc < 20);
    check_val({tag, "_lat"},  LW'(cyc), LW'(2));
    check_val({tag, "_hit"},  LW'(lookup_hit), LW'(eh));
    check_val({tag, "_data"}, lookup_data, edata);
    if (eh) check_val({tag, "_dirty"}, LW'(lookup_dirty), LW'(ed));
    lookup_req  = 1'b0;
    lookup_addr = $urandom;
  endtask

  task automatic do_insert(input logic [AW-1:0] a, input logic [LW-1:0] d, input bit dirty,
                           input int wb_delay, input string tag);
    bit            ewb, seen_wb = 1'b0;
    logic [AW-1:0] ewa;
    logic [LW-1:0] ewd;
    int            cyc = 0, held = 0;
    model_insert(a, d, dirty, ewb, ewa, ewd);
    insert_addr  = a;
    insert_data  = d;
    insert_dirty = dirty;
    insert_req   = 1'b1;
    while (cyc < 40) begin
      @(posedge clk); #1; cyc++;
      wb_resp = 1'b0;
      if (insert_ack) break;
      if (wb_write) begin
        if (!seen_wb) check_val({tag, "_wb_start"}, LW'(cyc), LW'(2));
        seen_wb = 1'b1;
        if (ewb) begin
          check_val({tag, "_wb_addr"}, LW'(wb_address), LW'(ewa));
          check_val({tag, "_wb_data"}, wb_wdata, ewd);
        end
        if (held == wb_delay) wb_resp = 1'b1;
        held++;
      end
    end
    check_val({tag, "_ack"},   LW'(insert_ack), LW'(1));
    check_val({tag, "_wb"},    LW'(seen_wb), LW'(ewb));
    check_val({tag, "_lat"},   LW'(cyc), ewb ? LW'(4 + wb_delay) : LW'(2));
    check_val({tag, "_wbend"}, LW'(wb_write), LW'(0));
    insert_req = 1'b0;
    wb_resp    = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_resp"},  LW'(lookup_resp), LW'(0));
    check_val({tag, "_hit"},   LW'(lookup_hit), LW'(0));
    check_val({tag, "_ldata"}, lookup_data, '0);
    check_val({tag, "_ack"},   LW'(insert_ack), LW'(0));
    check_val({tag, "_wbw"},   LW'(wb_write), LW'(0));
    check_val({tag, "_wba"},   LW'(wb_address), LW'(0));
    check_val({tag, "_wbd"},   wb_wdata, '0);
`ifdef VICTIM_CACHE_STATS_EN
    check_val({tag, "_sh"}, LW'(stat_hits), LW'(0));
    check_val({tag, "_sm"}, LW'(stat_misses), LW'(0));
    check_val({tag, "_sw"}, LW'(stat_writebacks), LW'(0));
`endif
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    lookup_req = 1'b0; insert_req = 1'b0; wb_resp = 1'b0;
    lookup_addr = '0; insert_addr = '0; insert_data = '0; insert_dirty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] line_a, line_b;
    bit            eh, ed, ewb;
    logic [LW-1:0] edata, ewd;
    logic [AW-1:0] ewa;
    int            cyc;

    apply_reset();

    // Insert then exclusive lookup.
    line_a = rand_line();
    do_insert(32'h1000, line_a, 1'b0, 0, "ins1");
    do_lookup(32'h1000, "lk1_hit");
    do_lookup(32'h1000, "lk1_miss");

    // Fill, then displace a dirty line with a slow downstream.
    do_insert(32'h1000, rand_line(), 1'b1, 0, "fill0");
    do_insert(32'h2000, rand_line(), 1'b0, 0, "fill1");
    do_insert(32'h3000, rand_line(), 1'b0, 0, "fill2");
    do_insert(32'h4000, rand_line(), 1'b0, 0, "fill3");
    do_insert(32'h5000, rand_line(), 1'b0, 5, "evict_dirty");
    do_lookup(32'h5000, "lk5");

    // Refill the freed slot, then displace a clean round-robin victim.
    do_insert(32'h6000, rand_line(), 1'b0, 0, "fill_free");
    do_insert(32'h7000, rand_line(), 1'b0, 0, "evict_clean");
    do_lookup(32'h2000, "lk_dropped");

    // Simultaneous requests: lookup is served first.
    model_lookup(32'h6000, eh, edata, ed);
    line_b = rand_line();
    model_insert(32'h8000, line_b, 1'b0, ewb, ewa, ewd);
    lookup_addr = 32'h6000; lookup_req = 1'b1;
    insert_addr = 32'h8000; insert_data = line_b; insert_dirty = 1'b0; insert_req = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!lookup_resp && cyc < 20);
    check_val("both_lk_lat",  LW'(cyc), LW'(2));
    check_val("both_lk_hit",  LW'(lookup_hit), LW'(eh));
    check_val("both_lk_data", lookup_data, edata);
    check_val("both_ack_early", LW'(insert_ack), LW'(0));
    lookup_req = 1'b0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!insert_ack && cyc < 20);
    check_val("both_ack_lat", LW'(cyc), LW'(4));
    insert_req = 1'b0;

    // Same line at a different offset merges into one dirty entry.
    do_insert(32'h2000, rand_line(), 1'b1, 0, "merge_a");
    line_b = rand_line();
    do_insert(32'h201F, line_b, 1'b0, 0, "merge_b");
    do_lookup(32'h2000, "merge_lk");
    do_lookup(32'h2000, "merge_lk2");

    // Randomized traffic over a small address pool.
    for (int k = 0; k < 80; k++) begin
      logic [AW-1:0] a;
      a = (AW'($urandom_range(1, 8)) << 12) | AW'($urandom_range(0, 31));
      if ($urandom_range(0, 9) < 4)
        do_lookup(a, $sformatf("rnd%0d_lk", k));
      else
        do_insert(a, rand_line(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  $sformatf("rnd%0d_ins", k));
    end
`ifdef VICTIM_CACHE_STATS_EN
    // Counters have been running since the first reset, as has the model.
    check_val("stat_hits",   LW'(stat_hits), LW'(m_hits));
    check_val("stat_misses", LW'(stat_misses), LW'(m_misses));
    check_val("stat_wbs",    LW'(stat_writebacks), LW'(m_wbs));
`endif

    // Reset while a writeback is outstanding.
    apply_reset();
    do_insert(32'hA000, rand_line(), 1'b1, 0, "rfill0");
    do_insert(32'hB000, rand_line(), 1'b1, 0, "rfill1");
    do_insert(32'hC000, rand_line(), 1'b1, 0, "rfill2");
    do_insert(32'hD000, rand_line(), 1'b1, 0, "rfill3");
    insert_addr = 32'hE000; insert_data = rand_line(); insert_dirty = 1'b1; insert_req = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!wb_write && cyc < 20);
    check_val("rst_wb_seen", LW'(wb_write), LW'(1));
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("rst_wb_drop", LW'(wb_write), LW'(0));
    check_val("rst_no_ack",  LW'(insert_ack), LW'(0));
    insert_req = 1'b0;
    check_idle_outputs("midwb_rst");
    rst_n = 1'b1;
    model_reset();
    do_lookup(32'hA000, "post_rst_a");
    do_lookup(32'hB000, "post_rst_b");
    do_lookup(32'hC000, "post_rst_c");
    do_lookup(32'hD000, "post_rst_d");
    do_lookup(32'hE000, "post_rst_e");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_victim_cache
`default_nettype wire
